// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin arbiter with burst lock sharing one synchronous memory port
module mem_port_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int ADDR_W   = 16,
  parameter int DATA_W   = 32,
  parameter int LOCK_MAX = 64
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ-1:0]        lock,
  input  logic [NUM_REQ-1:0]        we,
  input  logic [NUM_REQ*ADDR_W-1:0] addr,
  input  logic [NUM_REQ*DATA_W-1:0] wdata,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [NUM_REQ-1:0]        rvalid,
  output logic [DATA_W-1:0]         rdata,
  output logic                      mem_clk,
  output logic                      mem_we,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic [DATA_W-1:0]         mem_write_data,
  input  logic [DATA_W-1:0]         mem_read_data
);
  localparam int IW = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1;
  localparam int CW = $clog2(LOCK_MAX + 1);
  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] LOCKED = 1'b1;
  logic [0:0]    state;
  logic [IW-1:0] rr_ptr, owner, win, sel, idx, tag1, tag2;
  logic [CW-1:0] lock_cnt, cnt_nxt;
  logic          found, accept, rv1, rv2;
  // round-robin scan: first requester at or after rr_ptr
  always_comb begin
    win   = '0;
    found = 1'b0;
    idx   = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      idx = IW'((int'(rr_ptr) + j) % NUM_REQ);
      if (!found && req[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end
  assign sel     = state == LOCKED ? owner : win;
  assign accept  = reset_n && (state == LOCKED ? req[owner] : found);
  assign gnt     = accept ? NUM_REQ'(1) << sel : '0;
  assign cnt_nxt = state == IDLE ? CW'(1) : lock_cnt + CW'(1);
  assign rvalid  = rv2 ? NUM_REQ'(1) << tag2 : '0;
  assign rdata   = mem_read_data;
  assign mem_clk = clk;
  // arbitration state: pointer advance, lock entry, counted or voluntary release
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      owner    <= '0;
      lock_cnt <= '0;
    end else if (state == LOCKED && !req[owner]) begin
      state    <= IDLE;
      lock_cnt <= '0;
    end else if (accept) begin
      rr_ptr <= sel == IW'(NUM_REQ - 1) ? '0 : sel + IW'(1);
      owner  <= sel;
      if (lock[sel] && cnt_nxt < CW'(LOCK_MAX)) begin
        state    <= LOCKED;
        lock_cnt <= cnt_nxt;
      end else begin
        state    <= IDLE;
        lock_cnt <= '0;
      end
    end
  end
  // memory command registers; write data only changes on writes
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_we         <= 1'b0;
      mem_addr       <= '0;
      mem_write_data <= '0;
    end else begin
      mem_we <= accept && we[sel];
      if (accept) mem_addr <= addr[int'(sel)*ADDR_W +: ADDR_W];
      if (accept && we[sel]) mem_write_data <= wdata[int'(sel)*DATA_W +: DATA_W];
    end
  end
  // two-stage read tag pipeline matching the memory's latency
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rv1  <= 1'b0;
      rv2  <= 1'b0;
      tag1 <= '0;
      tag2 <= '0;
    end else begin
      rv1  <= accept && !we[sel];
      tag1 <= sel;
      rv2  <= rv1;
      tag2 <= tag1;
    end
  end
endmodule
